muldiv_controller: RTL and testbench
====================================

Name: muldiv_controller

Overview:
- Iterative multiply/divide sequencer for the MIPS execute stage.
- Owns the HI/LO architectural registers and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Runs a shared 32-iteration shift/add-subtract datapath and raises busy so the pipeline stalls on MFHI/MFLO.
- Inputs arrive after operand select; the opcode/funct decode and immediate handling are done upstream.

Parameters:
- ITERATIONS, 32: shift/add or shift/subtract steps per operation. Must equal the operand width of 32.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- reset_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- funct  input  6  R-type funct: MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B, MTHI 0x11, MTLO 0x13
- op_a  input  32  rs value (multiplicand / dividend / MTHI-MTLO source)
- op_b  input  32  rt value (multiplier / divisor)
- busy  output  1  high while an operation is in flight (state != IDLE)
- done  output  1  one-cycle pulse in the first cycle new HI/LO are visible
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset: reset_n=0 at a rising edge forces state IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset applies mid-operation; the partial result is discarded.
- States: IDLE, MUL, DIV, FIXUP.
- IDLE, start=1, funct MULT or MULTU:
  - Latch |op_a| and |op_b| (raw values for MULTU).
  - Latch sign = a[31]^b[31] (MULT only).
  - Go to MUL.
- IDLE, start=1, funct DIV or DIVU:
  - Latch magnitudes (raw values for DIVU), quotient sign a[31]^b[31], remainder sign a[31].
  - Flag div0 if op_b==0.
  - Go to DIV.
- IDLE, start=1, MTHI: hi<=op_a at that edge, stay IDLE, no busy, no done. MTLO does the same for lo.
- IDLE, start=1, any other funct: ignored.
- start while busy: ignored; no queueing. hi/lo hold their old values until the operation completes.
- MUL: unsigned shift-add over a 64-bit accumulator, one multiplier bit per cycle. After ITERATIONS cycles go to FIXUP.
- DIV: restoring division, one quotient bit per cycle. A 33-bit trial subtract of the divisor from the partial remainder decides each bit. After ITERATIONS cycles go to FIXUP.
- FIXUP:
  - MUL: two's-complement negate the 64-bit product if sign=1.
  - DIV: negate the quotient if quotient sign=1; negate the remainder if remainder sign=1.
  - Write hi/lo at the FIXUP edge and return to IDLE.
  - Register done so it is 1 in the following cycle only.
- Mapping: MUL gives {hi,lo} = 64-bit product. DIV gives lo=quotient, hi=remainder.
- Divide by zero: full latency is still taken, then lo=32'hFFFFFFFF, hi=op_a as latched, no sign fixup. Applies to DIV and DIVU.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (falls out of the magnitude path).
- Latency: start sampled at edge 0, MUL/DIV occupy cycles 1..32, FIXUP is cycle 33. hi/lo are updated and done=1 in cycle 34. busy=1 in cycles 1..33.
- Back-to-back: a new start in cycle 34 (IDLE, done=1) is accepted.
- Operand capture: op_a/op_b may change after the start cycle with no effect.
- Counter: 6-bit, cleared on entry to MUL/DIV. MUL/DIV exits when the count reaches ITERATIONS-1.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy cycles 1..33, done pulse cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD (−3) × 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Also MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
- DIV −7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 -> lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x12345678 / 0 -> done at cycle 34, lo=0xFFFFFFFF, hi=0x12345678.
- MTHI 0xCAFEBABE in IDLE -> hi updated next cycle, busy and done stay 0. MTLO with start asserted in cycle 10 of a DIV -> ignored, lo receives the DIV result.
- Start MULT, drop reset_n in cycle 15 -> next cycle busy=0, hi=lo=0, no done. A new MULTU 3×5 then completes with lo=15.

Source files
------------

// File: rtl/muldiv_controller.sv
// ---------------------------------------------------------------------------
// muldiv_controller
//   Iterative multiply/divide sequencer for the MIPS execute stage.
//   Owns the HI/LO registers. It serves MULT, MULTU, DIV, DIVU, MTHI and
//   MTLO on a shared 64-bit shift datapath that runs one step per cycle.
//
// Ports
//   clk      in   1   system clock, rising edge
//   reset_n  in   1   synchronous active-low reset
//   start    in   1   request, sampled only in IDLE
//   funct    in   6   R-type funct code
//   op_a     in  32   rs value (multiplicand / dividend / MTHI-MTLO source)
//   op_b     in  32   rt value (multiplier / divisor)
//   busy     out  1   operation in flight (state != IDLE)
//   done     out  1   one-cycle pulse in the first cycle new HI/LO are visible
//   hi       out 32   HI register
//   lo       out 32   LO register
//
// Handshake: start is only looked at while busy=0. An accepted MULT/DIV
// raises busy from the next cycle until the FIXUP cycle, inclusive. done
// follows in the next cycle, with HI/LO already updated. A start seen
// while busy=1 is dropped and never queued.
// ---------------------------------------------------------------------------
module muldiv_controller #(
    parameter int ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [5:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] LAST    = 6'(ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIXUP} state_t;

    state_t      state, state_next;
    logic [5:0]  cnt;
    logic [63:0] acc;      // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
    logic [31:0] operand;  // MUL: |multiplicand|; DIV: |divisor|
    logic        is_div;
    logic        sign;     // product sign (MUL) or quotient sign (DIV)
    logic        rsign;
    logic        div0;

    logic        is_mul_op, is_div_op, signed_op;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] trial;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix, rem_fix;

    assign busy = (state != IDLE);

    // Operand decode and magnitudes. Negating 0x80000000 yields 0x80000000.
    // As an unsigned magnitude that is the correct value.
    always_comb begin
        is_mul_op = (funct == F_MULT) || (funct == F_MULTU);
        is_div_op = (funct == F_DIV)  || (funct == F_DIVU);
        signed_op = (funct == F_MULT) || (funct == F_DIV);
        abs_a     = (signed_op && op_a[31]) ? (~op_a + 32'd1) : op_a;
        abs_b     = (signed_op && op_b[31]) ? (~op_b + 32'd1) : op_b;
    end

    // One datapath step for each operation type.
    always_comb begin
        // Shift-add: add the multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set. Then shift the 65-bit result right.
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);
        mul_next = {mul_sum, acc[31:1]};
        // Restoring divide: shift the next dividend bit into the remainder and
        // try subtracting the divisor. Bit 32 of the result set means borrow,
        // so the shifted remainder is kept and the quotient bit is 0.
        trial    = {acc[63:32], acc[31]} - {1'b0, operand};
        div_next = trial[32] ? {acc[62:0], 1'b0}
                             : {trial[31:0], acc[30:0], 1'b1};
        prod_fix = sign  ? (~acc + 64'd1) : acc;
        quot_fix = sign  ? (~acc[31:0] + 32'd1)  : acc[31:0];
        rem_fix  = rsign ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start && is_mul_op)      state_next = MUL;
                else if (start && is_div_op) state_next = DIV;
            end
            MUL:     if (cnt == LAST) state_next = FIXUP;
            DIV:     if (cnt == LAST) state_next = FIXUP;
            FIXUP:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt     <= '0;
            acc     <= '0;
            operand <= '0;
            is_div  <= 1'b0;
            sign    <= 1'b0;
            rsign   <= 1'b0;
            div0    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_mul_op) begin
                            acc     <= {32'd0, abs_b};
                            operand <= abs_a;
                            sign    <= signed_op && (op_a[31] ^ op_b[31]);
                            is_div  <= 1'b0;
                            cnt     <= '0;
                        end else if (is_div_op) begin
                            acc     <= {32'd0, abs_a};
                            operand <= abs_b;
                            sign    <= signed_op && (op_a[31] ^ op_b[31]);
                            rsign   <= signed_op && op_a[31];
                            div0    <= (op_b == 32'd0);
                            is_div  <= 1'b1;
                            cnt     <= '0;
                        end else if (funct == F_MTHI) begin
                            hi <= op_a;
                        end else if (funct == F_MTLO) begin
                            lo <= op_a;
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 6'd1;
                end
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 6'd1;
                end
                FIXUP: begin
                    done <= 1'b1;
                    if (is_div) begin
                        if (div0) begin
                            // With a zero divisor every trial succeeds, so the
                            // remainder ends up as the latched dividend.
                            lo <= 32'hFFFF_FFFF;
                            hi <= acc[63:32];
                        end else begin
                            lo <= quot_fix;
                            hi <= rem_fix;
                        end
                    end else begin
                        {hi, lo} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_controller.sv
// ---------------------------------------------------------------------------
// tb_muldiv_controller
//   Directed-vector bench for muldiv_controller. The driver pushes each
//   hand-computed {hi,lo} into exp_q. The monitor pops and compares it
//   whenever done is seen.
// ---------------------------------------------------------------------------
module tb_muldiv_controller;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic [63:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    muldiv_controller #(.ITERATIONS(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .funct   (funct),
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (reset_n === 1'b1 && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no result pending");
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("result_hi", {32'd0, hi}, {32'd0, e[63:32]});
                check("result_lo", {32'd0, lo}, {32'd0, e[31:0]});
            end
        end
    end

    // driver tasks; the caller is at a negative edge when a task is entered
    task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        funct = f;
        op_a  = a;
        op_b  = b;
        @(negedge clk);
        start = 1'b0;
        op_a  = $urandom;
        op_b  = $urandom;
    endtask

    // Issues one MULT/DIV and tracks latency. If inject > 0, an MTLO with
    // 0xDEADBEEF is asserted in that busy cycle. The task returns at the
    // negative edge of the done cycle, so the next call lands in that cycle.
    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input int inject);
        int cyc;
        logic busy_ok;
        exp_q.push_back({e_hi, e_lo});
        start_op(f, a, b);
        cyc = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (cyc == inject) begin
                start = 1'b1;
                funct = 6'h13;
                op_a  = 32'hDEADBEEF;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({name, "_latency"}, 64'(cyc), 64'd34);
        check({name, "_busy_window"}, {63'd0, busy_ok}, 64'd1);
        check({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        funct   = 6'h00;
        op_a    = 32'd0;
        op_b    = 32'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hi", {32'd0, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        reset_n = 1'b1;

        run_op("multu_max", 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0);
        run_op("mult_neg",  6'h18, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 0);
        run_op("mult_min",  6'h18, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0);
        run_op("div_neg",   6'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("divu_mtlo", 6'h1B, 32'd100,      32'd7,        32'd2,        32'd14,       10);
        run_op("div_ovf",   6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0);
        run_op("divu_zero", 6'h1B, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 0);

        // MTHI in IDLE: the write is visible next cycle, with no busy and no done.
        @(negedge clk);
        start_op(6'h11, 32'hCAFEBABE, 32'd0);
        check("mthi_hi", {32'd0, hi}, {32'd0, 32'hCAFEBABE});
        check("mthi_lo_kept", {32'd0, lo}, {32'd0, 32'hFFFFFFFF});
        check("mthi_busy", {63'd0, busy}, 64'd0);
        check("mthi_done", {63'd0, done}, 64'd0);

        // An unrecognised funct is ignored.
        start_op(6'h20, 32'h11111111, 32'h22222222);
        check("bad_funct_busy", {63'd0, busy}, 64'd0);
        check("bad_funct_hi", {32'd0, hi}, {32'd0, 32'hCAFEBABE});

        // Reset in cycle 15 of a MULT discards the operation.
        start_op(6'h18, 32'd5, 32'd6);
        repeat (14) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        check("midreset_done", {63'd0, done}, 64'd0);
        check("midreset_hi", {32'd0, hi}, 64'd0);
        check("midreset_lo", {32'd0, lo}, 64'd0);
        reset_n = 1'b1;
        run_op("multu_after_reset", 6'h19, 32'd3, 32'd5, 32'd0, 32'd15, 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
